// File: rtl/sha_ctrl.sv
// SHA-256 block sequencer: block handshake, round sequencing,
// per-word hash accumulation, multi-block chaining and digest output.
module sha_ctrl #(
  parameter int MSG_SIZ   = 512,
  parameter int HASH_SIZE = 256,
  parameter int BLK_CNT   = 6,
  parameter int MAX_CNT   = 63,
  parameter logic [HASH_SIZE-1:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_msg_valid,
  output logic                 o_msg_ready,
  input  logic [MSG_SIZ-1:0]   i_msg,
  input  logic                 i_last,
  output logic                 o_dp_en,
  output logic                 o_cnt_en,
  output logic [MSG_SIZ-1:0]   o_dp_msg,
  output logic                 o_first_blk,
  input  logic [BLK_CNT-1:0]   i_round_count,
  input  logic                 i_flag,
  input  logic [HASH_SIZE-1:0] i_dp_hash,
  output logic [HASH_SIZE-1:0] o_digest,
  output logic                 o_digest_valid,
  input  logic                 i_digest_ready,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int WDW   = BLK_CNT + 1;
  localparam int NWORD = HASH_SIZE / 32;
  localparam logic [WDW-1:0] WD_LIM = WDW'(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    ACCUM = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [MSG_SIZ-1:0]   msg_q, msg_d;
  logic                 last_q, last_d;
  logic                 first_q, first_d;
  logic                 trk_q, trk_d;
  logic [HASH_SIZE-1:0] h_q, h_d;
  logic [HASH_SIZE-1:0] dig_q, dig_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [HASH_SIZE-1:0] sum;

  // Chaining base is the IV for the first block, else the running hash.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NWORD; i++) begin
      sum[i*32 +: 32] = (first_q ? IV[i*32 +: 32] : h_q[i*32 +: 32])
                      + i_dp_hash[i*32 +: 32];
    end
  end

  always_comb begin
    state_d        = state_q;
    msg_d          = msg_q;
    last_d         = last_q;
    first_d        = first_q;
    trk_d          = trk_q;
    h_d            = h_q;
    dig_d          = dig_q;
    wd_d           = wd_q;
    o_msg_ready    = 1'b0;
    o_dp_en        = 1'b0;
    o_cnt_en       = 1'b0;
    o_digest_valid = 1'b0;
    o_err          = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_msg_ready = 1'b1;
        if (i_msg_valid) begin
          msg_d   = i_msg;
          last_d  = i_last;
          first_d = trk_q;
          state_d = LOAD;
        end
      end
      LOAD: begin
        o_dp_en = 1'b1;
        wd_d    = '0;
        if (i_round_count != '0) state_d = ERR;
        else                     state_d = RUN;
      end
      RUN: begin
        o_dp_en  = 1'b1;
        o_cnt_en = 1'b1;
        wd_d     = wd_q + 1'b1;
        if (i_flag)               state_d = ACCUM;
        else if (wd_q == WD_LIM)  state_d = ERR;
      end
      ACCUM: begin
        h_d     = sum;
        trk_d   = 1'b0;
        first_d = 1'b0;
        if (last_q) begin
          dig_d   = sum;
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        o_digest_valid = 1'b1;
        if (i_digest_ready) begin
          trk_d   = 1'b1;
          h_d     = '0;
          state_d = IDLE;
        end
      end
      ERR: begin
        o_err = 1'b1;
      end
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
      trk_q   <= 1'b1;
      h_q     <= '0;
      dig_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      last_q  <= last_d;
      first_q <= first_d;
      trk_q   <= trk_d;
      h_q     <= h_d;
      dig_q   <= dig_d;
      wd_q    <= wd_d;
    end
  end

  assign o_dp_msg    = msg_q;
  assign o_first_blk = first_q;
  assign o_digest    = dig_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sha_ctrl.sv
// Directed bench for sha_ctrl with a behavioural round-counter model.
// Compression outputs are chosen so known SHA-256 digests result.
module tb_sha_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_msg_valid;
  logic         o_msg_ready;
  logic [511:0] i_msg;
  logic         i_last;
  logic         o_dp_en;
  logic         o_cnt_en;
  logic [511:0] o_dp_msg;
  logic         o_first_blk;
  logic [5:0]   i_round_count;
  logic         i_flag;
  logic [255:0] i_dp_hash;
  logic [255:0] o_digest;
  logic         o_digest_valid;
  logic         i_digest_ready;
  logic         o_busy;
  logic         o_err;

  int checks = 0;
  int errors = 0;
  logic kill;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] H1 =
    256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] OVF =
    256'h6a09e666_bb67ae84_3c6ef371_a54ff539_510e527e_9b05688b_1f83d9aa_5be0cd18;
  localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h18};
  localparam logic [511:0] M_B1 = {
    128'h61626364_62636465_63646566_64656667,
    128'h65666768_66676869_6768696a_68696a6b,
    128'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f,
    128'h6d6e6f70_6e6f7071_80000000_00000000};
  localparam logic [511:0] M_B2 = {480'h0, 32'h1c0};

  sha_ctrl dut (
    .clk(clk), .reset(reset),
    .i_msg_valid(i_msg_valid), .o_msg_ready(o_msg_ready),
    .i_msg(i_msg), .i_last(i_last),
    .o_dp_en(o_dp_en), .o_cnt_en(o_cnt_en),
    .o_dp_msg(o_dp_msg), .o_first_blk(o_first_blk),
    .i_round_count(i_round_count), .i_flag(i_flag),
    .i_dp_hash(i_dp_hash), .o_digest(o_digest),
    .o_digest_valid(o_digest_valid),
    .i_digest_ready(i_digest_ready),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset)         i_round_count <= '0;
    else if (o_cnt_en) i_round_count <= i_round_count + 6'd1;
  end
  assign i_flag = (i_round_count == 6'd63) && !kill;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [255:0] wsub(input logic [255:0] a,
                                        input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = a[i*32 +: 32] - b[i*32 +: 32];
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic send(input logic [511:0] m, input logic l);
    int n = 0;
    i_msg = m;
    i_last = l;
    i_msg_valid = 1'b1;
    while (!o_msg_ready && n < 200) begin
      tick();
      n++;
    end
    chk("send_ready", o_msg_ready, 1);
    tick();
    i_msg_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_digest_valid && n < 200) begin
      tick();
      n++;
    end
    chk("wait_valid", o_digest_valid, 1);
  endtask

  initial begin
    reset = 1'b1;
    i_msg_valid = 1'b0;
    i_msg = '0;
    i_last = 1'b0;
    i_dp_hash = '0;
    i_digest_ready = 1'b0;
    kill = 1'b0;
    tick(2);
    chk("rst_ready", o_msg_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_dp_en", o_dp_en, 0);
    chk("rst_cnt_en", o_cnt_en, 0);
    chk("rst_digest", o_digest, 0);
    chk("rst_valid", o_digest_valid, 0);
    chk("rst_err", o_err, 0);
    chk("rst_first", o_first_blk, 0);
    reset = 1'b0;
    tick();

    // single block abc with exact latency
    i_dp_hash = wsub(ABC, IV);
    send(M_ABC, 1'b1);
    chk("load_dp_en", o_dp_en, 1);
    chk("load_cnt_en", o_cnt_en, 0);
    chk("load_msg", o_dp_msg, M_ABC);
    chk("load_first", o_first_blk, 1);
    tick();
    chk("run_cnt_en", o_cnt_en, 1);
    tick(63);
    chk("run_last_cnt_en", o_cnt_en, 1);
    tick();
    chk("accum_dp_en", o_dp_en, 0);
    chk("accum_valid", o_digest_valid, 0);
    tick();
    chk("abc_valid_t67", o_digest_valid, 1);
    chk("abc_digest", o_digest, ABC);

    // consumer stalls with a block offered
    i_msg = M_B1;
    i_last = 1'b0;
    i_msg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", o_digest_valid, 1);
      chk("hold_digest", o_digest, ABC);
      chk("hold_ready", o_msg_ready, 0);
    end
    i_msg_valid = 1'b0;
    i_digest_ready = 1'b1;
    tick();
    chk("release_busy", o_busy, 0);
    chk("release_ready", o_msg_ready, 1);
    chk("release_digest", o_digest, ABC);

    // two blocks, 5-cycle gap, ready held high beforehand
    i_dp_hash = wsub(H1, IV);
    send(M_B1, 1'b0);
    chk("b1_first", o_first_blk, 1);
    tick(66);
    chk("b1_idle", o_busy, 0);
    chk("b1_no_valid", o_digest_valid, 0);
    tick(5);
    i_dp_hash = wsub(TWO, H1);
    send(M_B2, 1'b1);
    chk("b2_msg", o_dp_msg, M_B2);
    tick(10);
    chk("b2_first", o_first_blk, 0);
    wait_valid();
    chk("two_digest", o_digest, TWO);
    tick();
    chk("two_early_ready_idle", o_busy, 0);

    // watchdog without round-done
    kill = 1'b1;
    i_dp_hash = wsub(ABC, IV);
    send(M_ABC, 1'b1);
    tick(65);
    chk("wd_not_yet", o_err, 0);
    tick();
    chk("wd_err", o_err, 1);
    chk("wd_dp_en", o_dp_en, 0);
    chk("wd_cnt_en", o_cnt_en, 0);
    chk("wd_ready", o_msg_ready, 0);
    tick(20);
    chk("wd_sticky", o_err, 1);
    chk("wd_no_valid", o_digest_valid, 0);
    kill = 1'b0;
    do_reset();
    chk("wd_cleared", o_err, 0);
    chk("wd_ready_back", o_msg_ready, 1);

    // reset mid-chain, then clean abc
    i_dp_hash = wsub(H1, IV);
    send(M_B1, 1'b0);
    for (int n = 0; n < 100 && i_round_count != 6'd30; n++) tick();
    chk("mid_round30", i_round_count, 30);
    do_reset();
    chk("mid_busy", o_busy, 0);
    chk("mid_digest", o_digest, 0);
    i_dp_hash = wsub(ABC, IV);
    send(M_ABC, 1'b1);
    chk("mid_first", o_first_blk, 1);
    wait_valid();
    chk("mid_abc_digest", o_digest, ABC);
    tick();

    // per-word wrap with no carry between words
    i_dp_hash = {8{32'hffffffff}};
    send(M_ABC, 1'b1);
    wait_valid();
    chk("ovf_digest", o_digest, OVF);
    tick();
    chk("ovf_idle", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
